// File: rtl/arm_mem_pkg.sv
// Shared definitions for the IF/MEM memory arbiter: FSM states, grant encoding and
// the width of the access wait counter.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  typedef enum logic {
    GntIf  = 1'b0,
    GntMem = 1'b1
  } grant_e;

  localparam int unsigned CntW = 4;

  // Counter preload so that the zero flag rises in the last ACCESS cycle.
  function automatic logic [CntW-1:0] wait_preload(input int unsigned wait_cycles);
    return CntW'(wait_cycles - 1);
  endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Down-counter pacing one memory access: synchronous load, decrement that stops at zero,
// and a zero flag marking the final access cycle.
module arb_wait_counter
  import arm_mem_pkg::*;
#(
  parameter int unsigned Width = CntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/if_mem_arbiter.sv
// Single-port memory arbiter between the fetch (IF) and load/store (MEM) stages.
// Optional ARB_ROUND_ROBIN_EN: simultaneous requests alternate instead of MEM always winning.
module if_mem_arbiter
  import arm_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_stall,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [CntW-1:0] CntInit = wait_preload(WAIT_CYCLES);

  state_e            state_q, state_d;
  grant_e            grant_q, grant_d;
  grant_e            pick;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic              any_req;

  assign any_req = if_req | mem_req;

`ifdef ARB_ROUND_ROBIN_EN
  grant_e last_q, last_d;

  // On a tie the requester not served last wins; last_q resets to IF so MEM wins first.
  always_comb begin
    if (if_req && mem_req) begin
      pick = (last_q == GntIf) ? GntMem : GntIf;
    end else if (mem_req) begin
      pick = GntMem;
    end else begin
      pick = GntIf;
    end
    last_d = last_q;
    if ((state_q == StIdle) && any_req) begin
      last_d = pick;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= GntIf;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: the older instruction in MEM always progresses first.
  always_comb begin
    pick = mem_req ? GntMem : GntIf;
  end
`endif

  arb_wait_counter #(
    .Width(CntW)
  ) u_wait_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cnt_load),
    .load_val(CntInit),
    .dec     (cnt_dec),
    .zero    (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d  = StAccess;
          grant_d  = pick;
          cnt_load = 1'b1;
          if (pick == GntMem) begin
            addr_d  = mem_addr;
            we_d    = mem_we;
            wdata_d = mem_wdata;
          end else begin
            addr_d  = if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end
        end
      end
      StAccess: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_d = StDone;
          if (grant_q == GntIf) begin
            if_rdata_d = m_rdata;
          end else if (!we_q) begin
            mem_rdata_d = m_rdata;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      grant_q     <= GntIf;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Memory-side outputs are forced to zero outside ACCESS so the bus is quiet when idle.
  always_comb begin
    m_en      = (state_q == StAccess);
    m_we      = m_en & we_q;
    m_addr    = m_en ? addr_q : '0;
    m_wdata   = m_we ? wdata_q : '0;
    if_ready  = (state_q == StDone) && (grant_q == GntIf);
    mem_ready = (state_q == StDone) && (grant_q == GntMem);
    if_stall  = if_req & ~if_ready;
    mem_stall = mem_req & ~mem_ready;
    if_rdata  = if_rdata_q;
    mem_rdata = mem_rdata_q;
  end

endmodule

// File: tb/tb_if_mem_arbiter.sv
// Directed bench for if_mem_arbiter (WAIT_CYCLES=4): vector table of single transfers plus
// collision, reset-abort and starvation sequences. Honours ARB_ROUND_ROBIN_EN.
module tb_if_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready, if_stall;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready, mem_stall;
  logic        m_en, m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #10 clk = ~clk;

  if_mem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .WAIT_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .if_stall (if_stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .mem_stall(mem_stall),
    .m_en     (m_en),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata)
  );

  // Memory model: fixed contents plus a write overlay.
  logic [31:0] wmem   [256];
  bit          wvalid [256];

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h10:  return 32'hE3A01005;
      32'h14:  return 32'hE1A00000;
      32'h40:  return 32'h0000002A;
      default: return a ^ 32'hA5A50000;
    endcase
  endfunction

  assign m_rdata = wvalid[m_addr[9:2]] ? wmem[m_addr[9:2]] : rom(m_addr);

  always @(posedge clk) begin
    if (m_en && m_we) begin
      wmem[m_addr[9:2]]   <= m_wdata;
      wvalid[m_addr[9:2]] <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and check per-cycle invariants.
  logic prev_if_rdy = 1'b0, prev_mem_rdy = 1'b0;
  task automatic tick();
    logic bad;
    @(negedge clk);
    if (rst_n) begin
      bad = (if_ready && mem_ready) || (if_ready && prev_if_rdy) ||
            (mem_ready && prev_mem_rdy) || (m_en && (if_ready || mem_ready)) ||
            (m_we && !m_en);
      chk("invariant", {27'd0, if_ready, mem_ready, prev_if_rdy, prev_mem_rdy, m_en},
          bad ? 32'hFFFF_FFFF : {27'd0, if_ready, mem_ready, prev_if_rdy, prev_mem_rdy, m_en});
    end
    prev_if_rdy  = rst_n & if_ready;
    prev_mem_rdy = rst_n & mem_ready;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    if_req = 1'b0;
    mem_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] rd;
    int lat, en_n, we_n, st_n;
    int mem_at, if_at;
    int order[$];
    int if_cnt, mem_cnt;

    vecs[0] = '{0, 0, 32'h10,  32'h0,        32'hE3A01005};
    vecs[1] = '{1, 0, 32'h40,  32'h0,        32'h0000002A};
    vecs[2] = '{1, 1, 32'h80,  32'hDEADBEEF, 32'h0000002A};  // store keeps old mem_rdata
    vecs[3] = '{1, 0, 32'h80,  32'h0,        32'hDEADBEEF};
    vecs[4] = '{0, 0, 32'h14,  32'h0,        32'hE1A00000};
    vecs[5] = '{1, 1, 32'h84,  32'h12345678, 32'hDEADBEEF};
    vecs[6] = '{0, 0, 32'h84,  32'h0,        32'h12345678};
    vecs[7] = '{1, 0, 32'h100, 32'h0,        32'hA5A50100};

    // Reset state
    tick();
    chk("rst_m_en", {31'd0, m_en}, 32'd0);
    chk("rst_m_we", {31'd0, m_we}, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_ready", {30'd0, if_ready, mem_ready}, 32'd0);
    chk("rst_rdata", if_rdata | mem_rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single transfers from the table
    foreach (vecs[k]) begin
      if (vecs[k].is_mem) begin
        mem_req = 1'b1; mem_we = vecs[k].we; mem_addr = vecs[k].addr; mem_wdata = vecs[k].wdata;
      end else begin
        if_req = 1'b1; if_addr = vecs[k].addr;
      end
      lat = 0; en_n = 0; we_n = 0; st_n = 0; rd = '0;
      for (int i = 1; i <= 40; i++) begin
        tick();
        if (m_en) en_n++;
        if (m_we) we_n++;
        if (vecs[k].is_mem ? mem_stall : if_stall) st_n++;
        if (vecs[k].is_mem ? mem_ready : if_ready) begin
          rd = vecs[k].is_mem ? mem_rdata : if_rdata;
          lat = i;
          break;
        end
      end
      if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
      chk($sformatf("v%0d_latency", k), lat, 5);
      chk($sformatf("v%0d_rdata", k), rd, vecs[k].exp_rdata);
      chk($sformatf("v%0d_m_en_cycles", k), en_n, 4);
      chk($sformatf("v%0d_m_we_cycles", k), we_n, vecs[k].we ? 4 : 0);
      chk($sformatf("v%0d_stall_cycles", k), st_n, 4);
      tick();
    end

    // Collision: MEM first, IF six cycles after mem_ready
    do_reset();
    tick();
    if_req = 1'b1; if_addr = 32'h10;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h40;
    mem_at = 0; if_at = 0;
    for (int i = 1; i <= 40 && if_at == 0; i++) begin
      tick();
      if (mem_ready) begin
        mem_at = i;
        chk("coll_mem_rdata", mem_rdata, 32'h2A);
        mem_req = 1'b0;
      end
      if (if_ready) begin
        if_at = i;
        chk("coll_if_rdata", if_rdata, 32'hE3A01005);
        if_req = 1'b0;
      end
    end
    chk("coll_mem_latency", mem_at, 5);
    chk("coll_if_gap", if_at - mem_at, 6);
    tick();

    // Reset in the 2nd ACCESS cycle of a store, then re-serve the held request
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h90; mem_wdata = 32'hCAFEF00D;
    tick();
    tick();
    chk("abort_in_access", {31'd0, m_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_m_en", {31'd0, m_en}, 32'd0);
    chk("abort_m_we", {31'd0, m_we}, 32'd0);
    chk("abort_ready", {30'd0, if_ready, mem_ready}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (mem_ready) begin
        lat = i;
        break;
      end
    end
    mem_req = 1'b0; mem_we = 1'b0;
    chk("abort_reserve_latency", lat, 5);
    tick();
    mem_req = 1'b1; mem_addr = 32'h90;
    rd = '0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (mem_ready) begin
        rd = mem_rdata;
        break;
      end
    end
    mem_req = 1'b0;
    chk("abort_store_readback", rd, 32'hCAFEF00D);
    tick();

    // Starvation: mem_req and if_req held high continuously
    do_reset();
    if_req = 1'b1; if_addr = 32'h14;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h40;
    if_cnt = 0; mem_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (if_ready) begin if_cnt++; order.push_back(0); end
      if (mem_ready) begin mem_cnt++; order.push_back(1); end
    end
    if_req = 1'b0; mem_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    while (order.size() < 3) order.push_back(9);
    chk("rr_grant0_mem", order[0], 1);
    chk("rr_grant1_if", order[1], 0);
    chk("rr_grant2_mem", order[2], 1);
`else
    chk("starve_if_ready_count", if_cnt, 0);
    chk("starve_mem_ready_count", mem_cnt, 5);
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
